// File: rtl/pacote_processador.sv
// Processor-wide constants shared by the register file and the scoreboard.
package pacote_processador;
   localparam int LARGURA_DADOS     = 32;
   localparam int LARGURA_REG       = 5;
   localparam int NUM_REGS          = 2 ** LARGURA_REG;
   localparam int LARGURA_PENDENTES = 6;
   localparam logic [LARGURA_REG-1:0] REG_ZERO = 5'd0;

   // Register-field bit positions inside a MIPS instruction word.
   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;
   localparam int RD_MSB = 15;
   localparam int RD_LSB = 11;
endpackage

// File: rtl/banco_registradores_placar_if.sv
// Issue/write-back bus of the register file. Valid/ready semantics: emitir is the
// issue request and parar is its combinational not-ready; an issue completes at a
// rising edge only when emitir=1 and parar=0. escrever is an unconditional strobe.
interface banco_registradores_placar_if #(
   parameter int LARGURA_DADOS     = 32,
   parameter int LARGURA_PENDENTES = 6
);
   logic [4:0]                   reg_s;
   logic [4:0]                   reg_t;
   logic                         usa_s;
   logic                         usa_t;
   logic                         emitir;
   logic [4:0]                   reg_destino_emitir;
   logic                         escreve_destino;
   logic                         escrever;
   logic [4:0]                   reg_destino_escrita;
   logic [LARGURA_DADOS-1:0]     dado_escrita;
   logic [LARGURA_DADOS-1:0]     dado_s;
   logic [LARGURA_DADOS-1:0]     dado_t;
   logic                         parar;
   logic [LARGURA_PENDENTES-1:0] pendentes;

   modport master (
      output reg_s, reg_t, usa_s, usa_t, emitir, reg_destino_emitir, escreve_destino,
             escrever, reg_destino_escrita, dado_escrita,
      input  dado_s, dado_t, parar, pendentes
   );

   modport slave (
      input  reg_s, reg_t, usa_s, usa_t, emitir, reg_destino_emitir, escreve_destino,
             escrever, reg_destino_escrita, dado_escrita,
      output dado_s, dado_t, parar, pendentes
   );
endinterface

// File: rtl/placar_registradores.sv
// Busy scoreboard: one busy bit per register, outstanding-write counter and the
// issue stall decision.
module placar_registradores
   import pacote_processador::*;
#(
   parameter int LARGURA_PEND = 6
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [LARGURA_REG-1:0]  reg_s,
   input  logic [LARGURA_REG-1:0]  reg_t,
   input  logic                    usa_s,
   input  logic                    usa_t,
   input  logic                    emitir,
   input  logic [LARGURA_REG-1:0]  reg_destino_emitir,
   input  logic                    escreve_destino,
   input  logic                    escrever,
   input  logic [LARGURA_REG-1:0]  reg_destino_escrita,
   output logic                    parar,
   output logic [LARGURA_PEND-1:0] pendentes
);
   logic [NUM_REGS-1:0]     ocupado;
   logic [NUM_REGS-1:0]     ocupado_prox;
   logic [LARGURA_PEND-1:0] pendentes_prox;
   logic raw_s, raw_t, waw, define, incrementa, decrementa;

   always_comb begin
      // A register being written back this cycle no longer blocks the issue.
      raw_s = usa_s && ocupado[reg_s] &&
              !(escrever && reg_destino_escrita == reg_s);
      raw_t = usa_t && ocupado[reg_t] &&
              !(escrever && reg_destino_escrita == reg_t);
      waw   = escreve_destino && ocupado[reg_destino_emitir] &&
              !(escrever && reg_destino_escrita == reg_destino_emitir);
      parar = !reset && emitir && (raw_s || raw_t || waw);

      define = emitir && escreve_destino && !parar && (reg_destino_emitir != REG_ZERO);

      // Same-register set and clear: the bit stays set and the count is unchanged.
      incrementa = define && !ocupado[reg_destino_emitir];
      decrementa = escrever && ocupado[reg_destino_escrita] &&
                   !(define && reg_destino_emitir == reg_destino_escrita);

      ocupado_prox = ocupado;
      if (escrever) ocupado_prox[reg_destino_escrita] = 1'b0;
      if (define)   ocupado_prox[reg_destino_emitir]  = 1'b1;
      ocupado_prox[0] = 1'b0;

      pendentes_prox = pendentes;
      if (incrementa && !decrementa)      pendentes_prox = pendentes + LARGURA_PEND'(1);
      else if (decrementa && !incrementa) pendentes_prox = pendentes - LARGURA_PEND'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ocupado   <= '0;
         pendentes <= '0;
      end else begin
         ocupado   <= ocupado_prox;
         pendentes <= pendentes_prox;
      end
   end
endmodule

// File: rtl/banco_registradores_placar.sv
// 32 x 32-bit MIPS register file with write-back bypass on both read ports and a
// busy scoreboard that stalls issue on pending sources or destination.
module banco_registradores_placar
   import pacote_processador::*;
#(
   parameter int LARGURA_DADOS     = pacote_processador::LARGURA_DADOS,
   parameter int NUM_REGS          = pacote_processador::NUM_REGS,
   parameter int LARGURA_PENDENTES = pacote_processador::LARGURA_PENDENTES
) (
   input logic                         clock,
   input logic                         reset,
   banco_registradores_placar_if.slave barramento
);
   logic [LARGURA_DADOS-1:0] registradores [NUM_REGS];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) registradores[i] <= '0;
      end else if (barramento.escrever && barramento.reg_destino_escrita != REG_ZERO) begin
         registradores[barramento.reg_destino_escrita] <= barramento.dado_escrita;
      end
   end

   // Register 0 is never written, so its stored value is always zero.
   always_comb begin
      barramento.dado_s = registradores[barramento.reg_s];
      barramento.dado_t = registradores[barramento.reg_t];
      if (barramento.escrever && barramento.reg_destino_escrita != REG_ZERO) begin
         if (barramento.reg_destino_escrita == barramento.reg_s)
            barramento.dado_s = barramento.dado_escrita;
         if (barramento.reg_destino_escrita == barramento.reg_t)
            barramento.dado_t = barramento.dado_escrita;
      end
   end

   placar_registradores #(
      .LARGURA_PEND (LARGURA_PENDENTES)
   ) u_placar (
      .clock               (clock),
      .reset               (reset),
      .reg_s               (barramento.reg_s),
      .reg_t               (barramento.reg_t),
      .usa_s               (barramento.usa_s),
      .usa_t               (barramento.usa_t),
      .emitir              (barramento.emitir),
      .reg_destino_emitir  (barramento.reg_destino_emitir),
      .escreve_destino     (barramento.escreve_destino),
      .escrever            (barramento.escrever),
      .reg_destino_escrita (barramento.reg_destino_escrita),
      .parar               (barramento.parar),
      .pendentes           (barramento.pendentes)
   );
endmodule

// File: tb/tb_banco_registradores_placar.sv
// Directed bench for banco_registradores_placar: a table of per-cycle vectors with
// hand-computed combinational outputs, then a reset sweep over all registers.
module tb_banco_registradores_placar;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   passou = 0;

   banco_registradores_placar_if #(.LARGURA_DADOS(32), .LARGURA_PENDENTES(6)) barr ();

   banco_registradores_placar dut (
      .clock      (clock),
      .reset      (reset),
      .barramento (barr)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic        emi;
      logic        esc_d;
      logic [4:0]  dst;
      logic        us;
      logic [4:0]  rs;
      logic        ut;
      logic [4:0]  rt;
      logic        wr_en;
      logic [4:0]  wr;
      logic [31:0] dado;
      logic [31:0] e_s;
      logic [31:0] e_t;
      logic        e_p;
      logic [5:0]  e_pend;
   } vetor_t;

   vetor_t vetores [23];

   function automatic vetor_t vec(logic rst, logic emi, logic esc_d, logic [4:0] dst,
                                  logic us, logic [4:0] rs, logic ut, logic [4:0] rt,
                                  logic wr_en, logic [4:0] wr, logic [31:0] dado,
                                  logic [31:0] e_s, logic [31:0] e_t, logic e_p,
                                  logic [5:0] e_pend);
      vetor_t v;
      v.rst = rst; v.emi = emi; v.esc_d = esc_d; v.dst = dst;
      v.us = us; v.rs = rs; v.ut = ut; v.rt = rt;
      v.wr_en = wr_en; v.wr = wr; v.dado = dado;
      v.e_s = e_s; v.e_t = e_t; v.e_p = e_p; v.e_pend = e_pend;
      return v;
   endfunction

   task automatic confere(string nome, logic [31:0] atual, logic [31:0] esperado);
      total++;
      if (atual === esperado) passou++;
      else $display("FAIL %s: got %h expected %h", nome, atual, esperado);
   endtask

   task automatic dirige(vetor_t v);
      reset                    = v.rst;
      barr.emitir              = v.emi;
      barr.escreve_destino     = v.esc_d;
      barr.reg_destino_emitir  = v.dst;
      barr.usa_s               = v.us;
      barr.reg_s               = v.rs;
      barr.usa_t               = v.ut;
      barr.reg_t               = v.rt;
      barr.escrever            = v.wr_en;
      barr.reg_destino_escrita = v.wr;
      barr.dado_escrita        = v.dado;
   endtask

   initial begin
      //             rst emi escd dst  us rs  ut rt  wen wr  dado           e_s            e_t            p  pend
      vetores[0]  = vec(0, 0, 0, 0,  0, 5,  0, 31, 0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
      vetores[1]  = vec(0, 0, 0, 0,  0, 8,  0, 0,  1, 8,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0, 0);
      vetores[2]  = vec(0, 0, 0, 0,  0, 8,  0, 8,  0, 0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
      vetores[3]  = vec(0, 0, 0, 0,  0, 0,  0, 8,  1, 0,  32'h1234,     32'h0,        32'hDEADBEEF, 0, 0);
      vetores[4]  = vec(0, 1, 1, 0,  0, 0,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
      vetores[5]  = vec(0, 1, 1, 9,  0, 8,  0, 0,  0, 0,  32'h0,        32'hDEADBEEF, 32'h0,        0, 0);
      vetores[6]  = vec(0, 1, 0, 0,  1, 9,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        1, 1);
      vetores[7]  = vec(0, 1, 0, 0,  1, 9,  0, 0,  1, 9,  32'h7,        32'h7,        32'h0,        0, 1);
      vetores[8]  = vec(0, 0, 0, 0,  0, 9,  0, 0,  0, 0,  32'h0,        32'h7,        32'h0,        0, 0);
      vetores[9]  = vec(0, 1, 1, 10, 0, 0,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
      vetores[10] = vec(0, 1, 1, 10, 0, 0,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        1, 1);
      vetores[11] = vec(0, 1, 1, 10, 0, 0,  0, 0,  1, 10, 32'h55,       32'h0,        32'h0,        0, 1);
      vetores[12] = vec(0, 1, 0, 0,  0, 0,  1, 10, 0, 0,  32'h0,        32'h0,        32'h55,       1, 1);
      vetores[13] = vec(0, 1, 0, 0,  0, 11, 1, 10, 1, 11, 32'hAA,       32'hAA,       32'h55,       1, 1);
      vetores[14] = vec(0, 1, 0, 0,  0, 0,  0, 10, 0, 0,  32'h0,        32'h0,        32'h55,       0, 1);
      vetores[15] = vec(0, 1, 1, 12, 0, 0,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        0, 1);
      vetores[16] = vec(0, 1, 1, 13, 0, 0,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        0, 2);
      vetores[17] = vec(0, 0, 0, 0,  0, 11, 0, 12, 0, 0,  32'h0,        32'hAA,       32'h0,        0, 3);
      vetores[18] = vec(0, 1, 1, 14, 0, 12, 0, 0,  1, 12, 32'h3,        32'h3,        32'h0,        0, 3);
      vetores[19] = vec(0, 0, 0, 0,  0, 12, 0, 0,  0, 0,  32'h0,        32'h3,        32'h0,        0, 3);
      vetores[20] = vec(1, 1, 1, 15, 1, 10, 0, 0,  1, 20, 32'hFFFFFFFF, 32'h55,       32'h0,        0, 3);
      vetores[21] = vec(0, 1, 1, 14, 1, 10, 1, 13, 0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
      vetores[22] = vec(0, 0, 0, 0,  0, 20, 0, 8,  0, 0,  32'h0,        32'h0,        32'h0,        0, 1);

      dirige(vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0));
      repeat (2) @(posedge clock);

      for (int i = 0; i < 23; i++) begin
         @(negedge clock);
         dirige(vetores[i]);
         #2;
         confere($sformatf("v%0d dado_s", i), barr.dado_s, vetores[i].e_s);
         confere($sformatf("v%0d dado_t", i), barr.dado_t, vetores[i].e_t);
         confere($sformatf("v%0d parar", i), 32'(barr.parar), 32'(vetores[i].e_p));
         confere($sformatf("v%0d pendentes", i), 32'(barr.pendentes), 32'(vetores[i].e_pend));
      end

      // Reset with issue and write-back active, then every register must read zero.
      @(negedge clock);
      dirige(vec(1, 1, 1, 16, 0, 0, 0, 0, 1, 17, 32'hCAFE, 32'h0, 32'h0, 0, 0));
      #2;
      confere("reset parar", 32'(barr.parar), 32'h0);
      @(negedge clock);
      dirige(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0));
      #2;
      confere("sweep pendentes", 32'(barr.pendentes), 32'h0);
      for (int r = 0; r < 32; r++) begin
         barr.reg_s = 5'(r);
         barr.reg_t = 5'(31 - r);
         #1;
         confere($sformatf("sweep s%0d", r), barr.dado_s, 32'h0);
         confere($sformatf("sweep t%0d", 31 - r), barr.dado_t, 32'h0);
      end

      $display("%0d/%0d checks passed", passou, total);
      $finish;
   end
endmodule

// File: doc/banco_registradores_placar.md
Name: banco_registradores_placar

Overview:
- 32 x 32-bit MIPS register file with a per-register busy scoreboard.
- Sits at the write-back end of the destination-register path. The write-back stage delivers the destination selected upstream (rt or rd), together with its data.
- The issue stage presents source registers and the chosen destination. The block returns operand data and a stall when a source or destination register is still pending.
- Register $zero is hardwired to 0.

Parameters:
- LARGURA_DADOS, 32, data word width.
- NUM_REGS, 32, number of architectural registers. Fixed by the 5-bit register field; not to be changed.
- LARGURA_PENDENTES, 6, width of the outstanding-write counter. Must hold 0..31.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- reg_s  input  5  source register rs (bits 25-21) of issuing instruction.
- reg_t  input  5  source register rt (bits 20-16) of issuing instruction.
- usa_s  input  1  issuing instruction reads rs.
- usa_t  input  1  issuing instruction reads rt.
- emitir  input  1  issue request this cycle.
- reg_destino_emitir  input  5  destination selected by the issue-stage rt/rd select. Valid when emitir=1.
- escreve_destino  input  1  issuing instruction writes a register.
- escrever  input  1  write-back strobe.
- reg_destino_escrita  input  5  write-back destination register.
- dado_escrita  input  LARGURA_DADOS  write-back data.
- dado_s  output  LARGURA_DADOS  value of reg_s.
- dado_t  output  LARGURA_DADOS  value of reg_t.
- parar  output  1  issue must stall this cycle.
- pendentes  output  LARGURA_PENDENTES  number of registers currently busy.

Behaviour:
- Reset:
  - While reset=1 at a rising edge, all 32 registers are cleared to 0, all busy bits to 0, and pendentes to 0.
  - emitir and escrever are ignored in that cycle.
  - parar is forced to 0 while reset=1.
- Register write:
  - At the edge with escrever=1 and reg_destino_escrita!=0, the register takes dado_escrita.
  - A write to register 0 is discarded, and register 0 always reads 0.
- Reads:
  - Reads are combinational (zero latency).
  - Same-cycle bypass: if escrever=1 and reg_destino_escrita equals the read address and is non-zero, the output is dado_escrita instead of the stored value.
- Busy bits:
  - Busy clear: at an edge with escrever=1, busy[reg_destino_escrita] goes to 0. If that register was not busy, the data write still happens and the clear has no effect.
  - Busy set: at an edge with emitir=1, escreve_destino=1, parar=0 and reg_destino_emitir!=0, busy[reg_destino_emitir] goes to 1.
  - Simultaneous set and clear of the same register in one cycle: set wins, because the issuing instruction is newer. pendentes is unchanged in that case.
  - busy[0] is permanently 0.
- parar is combinational, and is 1 when emitir=1 and any of the following holds:
  - RAW on rs: usa_s=1 and busy[reg_s]=1, and the register is not being cleared by write-back this cycle.
  - RAW on rt: the same rule, using usa_t and reg_t.
  - WAW: escreve_destino=1 and busy[reg_destino_emitir]=1, and the register is not being cleared this cycle.
- Write-back relieves a pending register in the same cycle it is written. Operand data is then supplied by the bypass path.
- parar=0 whenever emitir=0.
- pendentes:
  - Equals the population count of the busy bits.
  - Updated at the edge: +1 on a set, -1 on a clear of a busy register, net 0 when both happen.
  - Never wraps, since the maximum is 31.
- No other state. No FSM beyond the busy vector; the scoreboard is the sequential element.

Decomposition:
- Shared package `pacote_processador`:
  - Constants LARGURA_DADOS=32, LARGURA_REG=5, REG_ZERO=5'd0.
  - Register-field bit positions: rs 25-21, rt 20-16, rd 15-11.
- One natural sub-module, `placar_registradores`. It holds the busy vector, the pendentes counter, and the parar logic.
- The top level holds the storage array and the bypass read muxes.

Test Plan:
- Reset, then reset low. Read reg_s=5, reg_t=31 -> dado_s=0, dado_t=0, pendentes=0, parar=0.
- escrever=1, reg_destino_escrita=8, dado_escrita=32'hDEADBEEF, with reg_s=8 in the same cycle -> dado_s=DEADBEEF (bypass). Next cycle, with escrever=0 -> still DEADBEEF.
- Write 32'h1234 to register 0, then read reg_s=0 -> 0. Issue with destination 0 -> busy not set, pendentes=0.
- Issue: emitir=1, escreve_destino=1, destination 9, parar=0 -> pendentes=1. Next cycle, emitir with usa_s=1, reg_s=9 -> parar=1. Add escrever=1 to reg 9 with data 7 -> parar=0 and dado_s=7 in the same cycle, then pendentes=0.
- Register 10 busy. Issue with destination 10 -> parar=1 (WAW). Same cycle as write-back to 10 -> parar=0. After the edge, busy[10]=1 and pendentes stays 1.
- With 3 registers busy, assert reset together with emitir and escrever -> after the edge all busy bits are 0, pendentes=0, all reads return 0, and no write was committed.
